pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Fetch-stage program counter: holds the PC register and selects the next PC.
//  Sources: sequential, branch (6 compare kinds), j/jal, jr, exception vector and eret.
//  Adds stall, a configurable reset vector and a return-address stack (RAS) for jal/jr $ra.
//  Sits between the instruction memory address and the decode-stage controller/register file.
// PARAMETERS
//  AW        32            PC/address width (>=28)
//  RESET_PC  32'h0000_3000 PC value loaded on reset
//  EXC_PC    32'h0000_4180 exception handler entry
//  RAS_DEPTH 4             RAS entries (power of 2, >=2)
// PORTS
//  clk       in  1       rising-edge clock
//  reset     in  1       synchronous, active-high
//  stall     in  1       hold PC; no RAS update
//  br_en     in  1       branch instruction in decode
//  br_op     in  3       0 beq, 1 bne, 2 blez, 3 bgtz, 4 bltz, 5 bgez; 6-7 never taken
//  rs_val    in  AW      rs operand (also jr target)
//  rt_val    in  AW      rt operand (beq/bne)
//  imm16     in  16      branch offset, in words
//  j_en      in  1       j or jal
//  link      in  1       jal: push return address
//  imm26     in  26      jump index
//  jr_en     in  1       jr
//  jr_ra     in  1       jr source is $31: pop RAS
//  exc       in  1       exception redirect
//  eret      in  1       return from exception
//  epc       in  AW      eret target
//  pc        out AW      current PC (register)
//  pc_plus4  out AW      pc+4
//  npc       out AW      combinational next PC
//  taken     out 1       npc differs from pc_plus4 due to a taken branch, jump, exc or eret
//  ras_top   out AW      top-of-stack return address (0 if empty)
//  ras_cnt   out log2(RAS_DEPTH)+1  valid RAS entries
// BEHAVIOUR
//  Reset (clk edge with reset=1): pc=RESET_PC, ras_cnt=0, all RAS entries 0; reset overrides everything.
//  npc priority, high to low:
//    exc -> EXC_PC
//    eret -> epc
//    jr_en -> rs_val
//    j_en -> {pc[AW-1:28], imm26, 2'b00}
//    br_en & cond -> pc+4+sext(imm16)<<2
//    otherwise pc+4
//  cond is signed on rs_val: blez rs<=0, bgtz rs>0, bltz rs[AW-1], bgez !rs[AW-1]; beq/bne compare rs_val with rt_val.
//  Register update each edge: pc <= npc, unless stall=1 and exc=0, in which case pc holds. exc overrides stall.
//  All adds wrap mod 2^AW; no overflow flag.
//  taken is 1 when the selected source is not the sequential pc+4 path, even if the value happens to equal pc+4.
//  RAS: push of pc+4 happens on an edge where j_en&link selects npc, stall=0, exc=0, eret=0.
//  RAS: pop happens on an edge where jr_en&jr_ra selects npc, stall=0, exc=0, eret=0.
//  Push when full: overwrite the oldest entry (circular); ras_cnt saturates at RAS_DEPTH.
//  Pop when empty: no change; ras_cnt stays 0; ras_top reads 0.
//  RAS is advisory only: npc on jr always uses rs_val; ras_top exists for future prediction and for checking.
//  Latency: npc is combinational from inputs and pc; pc and the RAS update one cycle later.
//  Illegal simultaneous j_en & jr_en: resolved by priority (jr wins); the push is suppressed.
// TESTING
//  1. reset=1 for 2 cycles, then release -> pc=0x3000, then 0x3004, 0x3008 on consecutive cycles.
//  2. pc=0x3010, beq, rs=rt=5, imm16=0xFFFC -> npc=0x3004, taken=1; bne with same operands -> npc=0x3014, taken=0.
//  3. bltz/bgez/blez/bgtz with rs=0xFFFFFFFF and with rs=0 -> taken flags 1/0/1/0 and 0/1/1/0.
//  4. jal at pc=0x3000, imm26=0x0C10 -> pc=0x3040, ras_top=0x3004, ras_cnt=1; then jr_ra with rs=0x3004 -> pc=0x3004, ras_cnt=0.
//  5. Five jals with RAS_DEPTH=4 -> ras_cnt=4, oldest entry lost; five pops -> ras_cnt=0, ras_top=0, pc still follows rs_val.
//  6. stall=1 with jal -> pc and RAS unchanged; stall=1 and exc=1 -> pc=0x4180, no push; reset mid-sequence -> pc=0x3000, ras_cnt=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC register with next-PC selection, stall, and an advisory return-address stack.
module pc_sequencer #(
  parameter int AW = 32,
  parameter logic [AW-1:0] RESET_PC = AW'('h0000_3000),
  parameter logic [AW-1:0] EXC_PC = AW'('h0000_4180),
  parameter int RAS_DEPTH = 4,
  localparam int PW = $clog2(RAS_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          stall_i,
  input  logic          br_en_i,
  input  logic [2:0]    br_op_i,
  input  logic [AW-1:0] rs_val_i,
  input  logic [AW-1:0] rt_val_i,
  input  logic [15:0]   imm16_i,
  input  logic          j_en_i,
  input  logic          link_i,
  input  logic [25:0]   imm26_i,
  input  logic          jr_en_i,
  input  logic          jr_ra_i,
  input  logic          exc_i,
  input  logic          eret_i,
  input  logic [AW-1:0] epc_i,
  output logic [AW-1:0] pc_o,
  output logic [AW-1:0] pc_plus4_o,
  output logic [AW-1:0] npc_o,
  output logic          taken_o,
  output logic [AW-1:0] ras_top_o,
  output logic [CW-1:0] ras_cnt_o
);
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0] ptr_q;
  logic [CW-1:0] cnt_q;
  logic          rs_neg, rs_zero, cond, br_take, push, pop, upd;
  logic [AW-1:0] br_tgt, j_tgt;

  assign pc_plus4_o = pc_q + AW'(4);
  assign rs_neg  = rs_val_i[AW-1];
  assign rs_zero = rs_val_i == '0;
  assign br_tgt  = pc_plus4_o + {{(AW-18){imm16_i[15]}}, imm16_i, 2'b00};
  assign j_tgt   = {pc_q[AW-1:28], imm26_i, 2'b00};

  always_comb begin
    cond = br_op_i == 3'd0 ? rs_val_i == rt_val_i :
           br_op_i == 3'd1 ? rs_val_i != rt_val_i :
           br_op_i == 3'd2 ? rs_neg | rs_zero :
           br_op_i == 3'd3 ? !rs_neg & !rs_zero :
           br_op_i == 3'd4 ? rs_neg :
           br_op_i == 3'd5 ? !rs_neg : 1'b0;
    br_take = br_en_i & cond;
    pc_d = exc_i   ? EXC_PC :
           eret_i  ? epc_i :
           jr_en_i ? rs_val_i :
           j_en_i  ? j_tgt :
           br_take ? br_tgt : pc_plus4_o;
    taken_o = exc_i | eret_i | jr_en_i | j_en_i | br_take;
  end

  // RAS moves only when the jump actually owns npc and the PC advances
  assign upd  = !stall_i | exc_i;
  assign push = !stall_i & !exc_i & !eret_i & !jr_en_i & j_en_i & link_i;
  assign pop  = !stall_i & !exc_i & !eret_i & jr_en_i & jr_ra_i & (cnt_q != '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q  <= RESET_PC;
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      if (upd) pc_q <= pc_d;
      if (push) begin
        ras_q[ptr_q] <= pc_plus4_o;
        ptr_q <= ptr_q + 1'b1;
        cnt_q <= cnt_q == CW'(RAS_DEPTH) ? cnt_q : cnt_q + 1'b1;
      end else if (pop) begin
        ptr_q <= ptr_q - 1'b1;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign pc_o      = pc_q;
  assign npc_o     = pc_d;
  assign ras_cnt_o = cnt_q;
  assign ras_top_o = cnt_q == '0 ? '0 : ras_q[ptr_q - 1'b1];
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of PC selection, branch conditions, stall/exception and the RAS.
module tb_pc_sequencer;
  logic        clk = 0, reset = 1, stall = 0, br_en = 0, j_en = 0, link = 0;
  logic        jr_en = 0, jr_ra = 0, exc = 0, eret = 0;
  logic [2:0]  br_op = 0;
  logic [31:0] rs_val = 0, rt_val = 0, epc = 0;
  logic [15:0] imm16 = 0;
  logic [25:0] imm26 = 0;
  logic [31:0] pc, pc_plus4, npc, ras_top;
  logic        taken;
  logic [2:0]  ras_cnt;
  int checks = 0, errors = 0;

  pc_sequencer dut (
    .clk_i(clk), .reset_i(reset), .stall_i(stall), .br_en_i(br_en), .br_op_i(br_op),
    .rs_val_i(rs_val), .rt_val_i(rt_val), .imm16_i(imm16), .j_en_i(j_en), .link_i(link),
    .imm26_i(imm26), .jr_en_i(jr_en), .jr_ra_i(jr_ra), .exc_i(exc), .eret_i(eret),
    .epc_i(epc), .pc_o(pc), .pc_plus4_o(pc_plus4), .npc_o(npc), .taken_o(taken),
    .ras_top_o(ras_top), .ras_cnt_o(ras_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall = 0; br_en = 0; j_en = 0; link = 0; jr_en = 0; jr_ra = 0; exc = 0; eret = 0;
  endtask

  logic [2:0] ops [4] = '{3'd4, 3'd5, 3'd2, 3'd3};
  logic       exp_neg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic       exp_zero [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] exp_top [5] = '{32'h30C4, 32'h3084, 32'h3044, 32'h0, 32'h0};

  initial begin
    tick(); tick();
    check("rst_pc", pc, 32'h3000);
    check("rst_cnt", 32'(ras_cnt), 0);
    check("rst_top", ras_top, 0);
    reset = 0;
    #1;
    check("seq_npc", npc, 32'h3004);
    check("seq_taken", 32'(taken), 0);
    check("seq_pc4", pc_plus4, 32'h3004);
    tick(); check("seq_pc1", pc, 32'h3004);
    tick(); check("seq_pc2", pc, 32'h3008);
    tick(); tick(); check("seq_pc4x", pc, 32'h3010);
    br_en = 1; br_op = 0; rs_val = 5; rt_val = 5; imm16 = 16'hFFFC; #1;
    check("beq_npc", npc, 32'h3004);
    check("beq_taken", 32'(taken), 1);
    br_op = 1; #1;
    check("bne_npc", npc, 32'h3014);
    check("bne_taken", 32'(taken), 0);
    for (int i = 0; i < 4; i++) begin
      br_op = ops[i];
      rs_val = 32'hFFFF_FFFF; #1;
      check($sformatf("br_neg_op%0d", ops[i]), 32'(taken), 32'(exp_neg[i]));
      rs_val = 0; #1;
      check($sformatf("br_zero_op%0d", ops[i]), 32'(taken), 32'(exp_zero[i]));
    end
    br_op = 6; rs_val = 5; #1;
    check("br_op6", 32'(taken), 0);
    idle();
    reset = 1; tick(); reset = 0;
    check("rst2_pc", pc, 32'h3000);
    j_en = 1; link = 1; imm26 = 26'h0C10; #1;
    check("jal_npc", npc, 32'h3040);
    check("jal_taken", 32'(taken), 1);
    tick();
    check("jal_pc", pc, 32'h3040);
    check("jal_top", ras_top, 32'h3004);
    check("jal_cnt", 32'(ras_cnt), 1);
    idle(); jr_en = 1; jr_ra = 1; rs_val = 32'h3004; tick();
    check("jr_pc", pc, 32'h3004);
    check("jr_cnt", 32'(ras_cnt), 0);
    check("jr_top", ras_top, 0);
    idle(); j_en = 1; link = 1;
    for (int i = 0; i < 5; i++) begin
      imm26 = 26'h0C10 + 26'(i * 'h10);
      tick();
      check($sformatf("push%0d_pc", i), pc, 32'h3040 + 32'(i * 'h40));
      check($sformatf("push%0d_cnt", i), 32'(ras_cnt), (i < 3) ? i + 1 : 4);
    end
    check("push_top", ras_top, 32'h3104);
    idle(); jr_en = 1; jr_ra = 1;
    for (int i = 0; i < 5; i++) begin
      rs_val = 32'h5000 + 32'(i * 4);
      tick();
      check($sformatf("pop%0d_pc", i), pc, 32'h5000 + 32'(i * 4));
      check($sformatf("pop%0d_cnt", i), 32'(ras_cnt), (i < 4) ? 3 - i : 0);
      check($sformatf("pop%0d_top", i), ras_top, exp_top[i]);
    end
    idle(); stall = 1; j_en = 1; link = 1; imm26 = 26'h0C10; tick();
    check("stall_pc", pc, 32'h5010);
    check("stall_cnt", 32'(ras_cnt), 0);
    exc = 1; #1;
    check("exc_taken", 32'(taken), 1);
    tick();
    check("exc_pc", pc, 32'h4180);
    check("exc_cnt", 32'(ras_cnt), 0);
    idle(); j_en = 1; link = 1; tick();
    check("jal2_pc", pc, 32'h3040);
    check("jal2_top", ras_top, 32'h4184);
    idle(); eret = 1; epc = 32'h2000; jr_en = 1; jr_ra = 1; tick();
    check("eret_pc", pc, 32'h2000);
    check("eret_cnt", 32'(ras_cnt), 1);
    idle(); j_en = 1; link = 1; jr_en = 1; rs_val = 32'h2100; tick();
    check("jjr_pc", pc, 32'h2100);
    check("jjr_cnt", 32'(ras_cnt), 1);
    idle(); j_en = 1; link = 1; reset = 1; tick(); reset = 0;
    check("rst3_pc", pc, 32'h3000);
    check("rst3_cnt", 32'(ras_cnt), 0);
    check("rst3_top", ras_top, 0);
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
